// File: rtl/adsr_env_pkg.sv
// Shared definitions for the ADSR envelope path: phase encodings and full-scale level.
// Also imported by the multiplier stage and the testbench.
package adsr_env_pkg;

  localparam int ADSR_LEVEL_W = 8;
  localparam int ADSR_STEP_W  = 8;
  localparam int LEVEL_MAX    = (1 << ADSR_LEVEL_W) - 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } phase_e;

endpackage

// File: rtl/adsr_env_sync_ff.sv
// Multi-stage synchroniser with asynchronous active-low clear to 0.
// STAGES must be at least 2; reused for other cross-domain control inputs.
module sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  // NOTE: every stage is cleared, so no stale pre-reset value can emerge after reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take its neighbour's old value.
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope generator, clocked by the slow clk_adsr tick; the gate is synchronised internally.
// Define ADSR_EXP_EN for exponential DECAY/RELEASE (low 3 bits of d_step/r_step are the shift).
module adsr_env
  import adsr_env_pkg::*;
#(
  parameter int LEVEL_W     = ADSR_LEVEL_W,
  parameter int STEP_W      = ADSR_STEP_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               gate,
  input  logic [STEP_W-1:0]  a_step,
  input  logic [STEP_W-1:0]  d_step,
  input  logic [LEVEL_W-1:0] sustain,
  input  logic [STEP_W-1:0]  r_step,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         phase,
  output logic               active
);

  // One extra bit over the wider operand keeps every sum and compare free of overflow.
  localparam int WIDE_W = ((LEVEL_W > STEP_W) ? LEVEL_W : STEP_W) + 1;
  typedef logic [WIDE_W-1:0] wide_t;
  localparam wide_t MAX_W = wide_t'({LEVEL_W{1'b1}});

  logic               gate_s;
  phase_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  wide_t              lvl_w, sum_w, target_w, dec_w;

  sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_gate_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d      (gate),
    .q      (gate_s)
  );

`ifdef ADSR_EXP_EN
  logic [2:0] shift;
  wide_t      diff_w;
  logic       unused_step_bits;
  assign unused_step_bits = ^{d_step, r_step};
`endif

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
    state_d  = state_q;
    level_d  = level_q;
    lvl_w    = wide_t'(level_q);
    sum_w    = lvl_w + wide_t'(a_step);
    target_w = (state_q == DECAY) ? wide_t'(sustain) : '0;
`ifdef ADSR_EXP_EN
    shift    = (state_q == DECAY) ? d_step[2:0] : r_step[2:0];
    diff_w   = (lvl_w > target_w) ? (lvl_w - target_w) : '0;
    dec_w    = (diff_w >> shift) + wide_t'(1);
`else
    dec_w    = (state_q == DECAY) ? wide_t'(d_step) : wide_t'(r_step);
`endif

    unique case (state_q)
      IDLE: begin
        if (gate_s) state_d = ATTACK;
      end
      ATTACK: begin
        if (!gate_s) begin
          state_d = RELEASE;
        end else if (sum_w >= MAX_W) begin
          level_d = '1;
          state_d = DECAY;
        end else begin
          level_d = LEVEL_W'(sum_w);
        end
      end
      DECAY, RELEASE: begin
        // Gate change wins over progress: DECAY drops to RELEASE, RELEASE retriggers in place.
        if ((state_q == DECAY) != gate_s) begin
          state_d = (state_q == DECAY) ? RELEASE : ATTACK;
        end else if (lvl_w <= target_w + dec_w) begin
          level_d = LEVEL_W'(target_w);
          state_d = (state_q == DECAY) ? SUSTAIN : IDLE;
        end else begin
          level_d = LEVEL_W'(lvl_w - dec_w);
        end
      end
      SUSTAIN: begin
        if (!gate_s) state_d = RELEASE;
        else         level_d = sustain;
      end
      default: begin
        state_d = IDLE;
        level_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  assign level  = level_q;
  assign phase  = state_q;
  assign active = (state_q != IDLE);

endmodule

// File: tb/tb_adsr_env.sv
// Directed testbench for adsr_env; expected envelopes are hand-computed per scenario.
// Linear-only scenarios are skipped when ADSR_EXP_EN is defined, and the exponential one is added.
module tb_adsr_env;
  import adsr_env_pkg::*;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       gate = 1'b0;
  logic [7:0] a_step = '0, d_step = '0, sustain = '0, r_step = '0;
  logic [7:0] level;
  logic [2:0] phase;
  logic       active;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  adsr_env dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .gate    (gate),
    .a_step  (a_step),
    .d_step  (d_step),
    .sustain (sustain),
    .r_step  (r_step),
    .level   (level),
    .phase   (phase),
    .active  (active)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_idle();
    int k = 0;
    gate   = 1'b0;
    r_step = 8'hFF;
    while (phase !== 3'(IDLE) && k < 300) begin
      step();
      k++;
    end
    n_total++;
    if (phase !== 3'(IDLE) || level !== 8'h00)
      $display("FAIL idle_wait: got phase=%0d level=%h after %0d edges, want phase=0 level=00", phase, level, k);
    else n_pass++;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #1;
    n_total++;
    if (level !== 8'h00 || phase !== 3'd0 || active !== 1'b0)
      $display("FAIL reset_initial: got level=%h phase=%0d active=%b, want 00/0/0", level, phase, active);
    else n_pass++;
    a_step = 8'h40; d_step = 8'h10; sustain = 8'h80; r_step = 8'h20;
    arst_n = 1'b1;
    gate   = 1'b1;
    step(2);
    n_total++;
    if (phase !== 3'(IDLE) || level !== 8'h00)
      $display("FAIL gate_latency_e1: got phase=%0d level=%h, want 0/00", phase, level);
    else n_pass++;
    step();
    n_total++;
    if (phase !== 3'(ATTACK) || level !== 8'h00 || active !== 1'b1)
      $display("FAIL gate_latency_e2: got phase=%0d level=%h active=%b, want 1/00/1", phase, level, active);
    else n_pass++;
    step();
    n_total++;
    if (phase !== 3'(ATTACK) || level !== 8'h40)
      $display("FAIL first_increment: got phase=%0d level=%h, want 1/40", phase, level);
    else n_pass++;
    #3 arst_n = 1'b0;
    #1;
    n_total++;
    if (level !== 8'h00 || phase !== 3'd0 || active !== 1'b0)
      $display("FAIL reset_mid_attack: got level=%h phase=%0d active=%b, want 00/0/0", level, phase, active);
    else n_pass++;
    gate = 1'b0;
    step(2);
    arst_n = 1'b1;
    step(3);
    n_total++;
    if (level !== 8'h00 || phase !== 3'(IDLE))
      $display("FAIL post_reset_idle: got level=%h phase=%0d, want 00/0", level, phase);
    else n_pass++;
  endtask

  task automatic test_linear();
    logic [7:0] lv [12];
    logic [2:0] ph [12];
    logic [7:0] rl [7];
    logic [2:0] rp [7];
    lv = '{8'h40, 8'h80, 8'hC0, 8'hFF, 8'hEF, 8'hDF, 8'hCF, 8'hBF, 8'hAF, 8'h9F, 8'h8F, 8'h80};
    ph = '{ATTACK, ATTACK, ATTACK, DECAY, DECAY, DECAY, DECAY, DECAY, DECAY, DECAY, DECAY, SUSTAIN};
    rl = '{8'h80, 8'h80, 8'h80, 8'h60, 8'h40, 8'h20, 8'h00};
    rp = '{SUSTAIN, SUSTAIN, RELEASE, RELEASE, RELEASE, RELEASE, IDLE};
    a_step = 8'h40; d_step = 8'h10; sustain = 8'h80; r_step = 8'h20;
    gate = 1'b1;
    step(3);
    for (int i = 0; i < 12; i++) begin
      step();
      n_total++;
      if (level !== lv[i] || phase !== ph[i])
        $display("FAIL linear_ads[%0d]: got level=%h phase=%0d, want level=%h phase=%0d", i, level, phase, lv[i], ph[i]);
      else n_pass++;
    end
    gate = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      n_total++;
      if (level !== rl[i] || phase !== rp[i])
        $display("FAIL linear_rel[%0d]: got level=%h phase=%0d, want level=%h phase=%0d", i, level, phase, rl[i], rp[i]);
      else n_pass++;
    end
    n_total++;
    if (active !== 1'b0)
      $display("FAIL linear_active_end: got active=%b, want 0", active);
    else n_pass++;
  endtask

  task automatic test_retrigger();
    logic [7:0] lv [4];
    logic [2:0] ph [4];
    lv = '{8'h80, 8'h60, 8'h60, 8'hA0};
    ph = '{RELEASE, RELEASE, ATTACK, ATTACK};
    a_step = 8'h40; d_step = 8'h10; sustain = 8'hA0; r_step = 8'h20;
    gate = 1'b1;
    step(13);
    n_total++;
    if (level !== 8'hA0 || phase !== 3'(SUSTAIN))
      $display("FAIL retrig_sustain: got level=%h phase=%0d, want A0/3", level, phase);
    else n_pass++;
    gate = 1'b0;
    step(3);
    n_total++;
    if (level !== 8'hA0 || phase !== 3'(RELEASE))
      $display("FAIL retrig_release_entry: got level=%h phase=%0d, want A0/4", level, phase);
    else n_pass++;
    gate = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++;
      if (level !== lv[i] || phase !== ph[i])
        $display("FAIL retrig[%0d]: got level=%h phase=%0d, want level=%h phase=%0d", i, level, phase, lv[i], ph[i]);
      else n_pass++;
    end
    go_idle();
  endtask

  task automatic test_sustain_max();
    logic [7:0] lv [4];
    logic [2:0] ph [4];
    lv = '{8'h80, 8'hFF, 8'hFF, 8'hFF};
    ph = '{ATTACK, DECAY, SUSTAIN, SUSTAIN};
    a_step = 8'h80; d_step = 8'h10; sustain = 8'hFF;
    gate = 1'b1;
    step(3);
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++;
      if (level !== lv[i] || phase !== ph[i])
        $display("FAIL sustain_max[%0d]: got level=%h phase=%0d, want level=%h phase=%0d", i, level, phase, lv[i], ph[i]);
      else n_pass++;
    end
    go_idle();
  endtask

  task automatic test_zero_attack_and_gate_race();
    a_step = 8'h00; d_step = 8'h10; sustain = 8'h80;
    gate = 1'b1;
    step(3);
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++;
      if (level !== 8'h00 || phase !== 3'(ATTACK))
        $display("FAIL zero_attack[%0d]: got level=%h phase=%0d, want 00/1", i, level, phase);
      else n_pass++;
    end
    gate = 1'b0;
    step();
    n_total++;
    if (level !== 8'h00 || phase !== 3'(ATTACK))
      $display("FAIL race_e0: got level=%h phase=%0d, want 00/1", level, phase);
    else n_pass++;
    a_step = 8'hC0;
    step();
    n_total++;
    if (level !== 8'hC0 || phase !== 3'(ATTACK))
      $display("FAIL race_e1: got level=%h phase=%0d, want C0/1", level, phase);
    else n_pass++;
    step();
    n_total++;
    if (level !== 8'hC0 || phase !== 3'(RELEASE))
      $display("FAIL race_release_wins: got level=%h phase=%0d, want C0/4", level, phase);
    else n_pass++;
    go_idle();
  endtask

  task automatic test_live_sustain();
    int k = 0;
    a_step = 8'h40; d_step = 8'h10; sustain = 8'h80;
    gate = 1'b1;
    step(3);
    while (phase !== 3'(SUSTAIN) && k < 40) begin
      step();
      k++;
    end
    n_total++;
    if (level !== 8'h80 || phase !== 3'(SUSTAIN))
      $display("FAIL live_sus_reach: got level=%h phase=%0d after %0d edges, want 80/3", level, phase, k);
    else n_pass++;
    sustain = 8'h30;
    #2;
    n_total++;
    if (level !== 8'h80)
      $display("FAIL live_sus_before_edge: got level=%h, want 80", level);
    else n_pass++;
    step();
    n_total++;
    if (level !== 8'h30 || phase !== 3'(SUSTAIN))
      $display("FAIL live_sus_follow: got level=%h phase=%0d, want 30/3", level, phase);
    else n_pass++;
    go_idle();
  endtask

`ifdef ADSR_EXP_EN
  task automatic test_exp_release();
    logic [7:0] lv [8];
    lv = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    a_step = 8'hFF; d_step = 8'h00; sustain = 8'hFF; r_step = 8'h01;
    gate = 1'b1;
    step(5);
    n_total++;
    if (level !== 8'(LEVEL_MAX) || phase !== 3'(SUSTAIN))
      $display("FAIL exp_top: got level=%h phase=%0d, want FF/3", level, phase);
    else n_pass++;
    gate = 1'b0;
    step(3);
    n_total++;
    if (level !== 8'hFF || phase !== 3'(RELEASE))
      $display("FAIL exp_rel_entry: got level=%h phase=%0d, want FF/4", level, phase);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      step();
      n_total++;
      if (level !== lv[i] || phase !== ((i == 7) ? 3'(IDLE) : 3'(RELEASE)))
        $display("FAIL exp_rel[%0d]: got level=%h phase=%0d, want level=%h", i, level, phase, lv[i]);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifndef ADSR_EXP_EN
    test_linear();
    test_retrigger();
`endif
    test_sustain_max();
    test_zero_attack_and_gate_race();
    test_live_sustain();
`ifdef ADSR_EXP_EN
    test_exp_release();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
